// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared funct3 encodings, FSM states and lane helpers for mem_access_ctrl
package mem_access_ctrl_pkg;

  localparam int DEFAULT_TIMEOUT = 16;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_SB:   return 4'b0001 << lo;
      F3_SH:   return 4'b0011 << {lo[1], 1'b0};
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_SB:   return {4{d[7:0]}};
      F3_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// rtl/mem_access_ctrl_load_extend.sv - load_extend: selects the byte/halfword lane and sign/zero extends
module load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    result = word;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - RV32I load/store sequencer with lane steering and memory timeout
// Optional feature: define MISALIGN_TRAP_EN to fail misaligned halfword/word accesses with err.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        legal;
  logic        trap;
  logic [31:0] load_word;

  load_extend u_load_extend (
    .funct3  (f3_q),
    .addr_lo (lane_q),
    .word    (mem_rdata),
    .result  (load_word)
  );

  always_comb begin
    legal = is_store ? store_f3_legal(funct3) : load_f3_legal(funct3);
`ifdef MISALIGN_TRAP_EN
    trap = legal && is_misaligned(funct3, addr[1:0]);
`else
    trap = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d    = funct3;
          lane_d  = addr[1:0];
          we_d    = is_store;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = is_store ? store_be(funct3, addr[1:0]) : 4'b0000;
          wdata_d = is_store ? store_lanes(funct3, wdata) : 32'h0;
          cnt_d   = 8'd0;
          // Rejected requests never touch memory and report through DONE next cycle
          if (legal && !trap) begin
            state_d = ACCESS;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (!we_q) begin
            rdata_d = load_word;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are qualified by the ACCESS state so an async reset clears them at once
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = done && err_q;
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req && we_q;
  assign mem_be    = mem_req ? be_q : 4'b0000;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl against a behavioural model
module tb_mem_access_ctrl;

  localparam int TB_TIMEOUT = 16;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] model_rdata;

  mem_access_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit m_legal(input bit st, input logic [2:0] f);
    if (st) return f <= 3'd2;
    return (f <= 3'd2) || (f == 3'd4) || (f == 3'd5);
  endfunction

  function automatic bit m_trap(input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = 1 << f[1:0];
    return TRAP_EN && ((a & 32'(sz - 1)) != 32'd0);
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] f, input logic [31:0] a);
    if (!st) return 4'h0;
    case (f)
      3'd0:    return 4'(1 << a[1:0]);
      3'd1:    return 4'(3 << (2 * a[1]));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f, input logic [31:0] d);
    case (f)
      3'd0:    return 32'(d[7:0]) * 32'h0101_0101;
      3'd1:    return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Expected latency (negedges after start), request cycles and err for one access
  task automatic m_expect(input bit st, input logic [2:0] f, input logic [31:0] a, input int d,
                          output int lat, output int reqs, output logic e);
    if (!m_legal(st, f) || m_trap(f, a)) begin
      lat = 1; reqs = 0; e = 1'b1;
    end else if (d < 0) begin
      lat = TB_TIMEOUT + 1; reqs = TB_TIMEOUT; e = 1'b1;
    end else begin
      lat = d + 2; reqs = d + 1; e = 1'b0;
    end
  endtask

  // Drives one request; memory answers after d request cycles (d<0: never)
  task automatic run_txn(input bit st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                         input int d, input logic [31:0] word,
                         output int lat, output int reqs, output logic e, output logic [31:0] rd,
                         output logic [3:0] be, output logic [31:0] mwd, output logic [31:0] ma,
                         output logic mwe, output bit busy_ok);
    bit fin;
    fin = 1'b0; lat = 0; reqs = 0; e = 1'bx; rd = 'x;
    be = '0; mwd = '0; ma = '0; mwe = 1'b0; busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f; addr = a; wdata = wd; mem_ready = 1'b0;
    for (int c = 1; c <= TB_TIMEOUT + 10 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_req) begin
        reqs++; be = mem_be; mwd = mem_wdata; ma = mem_addr; mwe = mem_we;
      end
      if (done) begin
        fin = 1'b1; lat = c; e = err; rd = rdata;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
      mem_ready = mem_req && (d >= 0) && (reqs > d);
      mem_rdata = mem_ready ? word : $urandom;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, err, mem_req, mem_we, mem_be} !== 9'h0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 0", {busy, done, err, mem_req, mem_we, mem_be});
    end
    tests_run++;
    if ({rdata, mem_addr, mem_wdata} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h %h expected 0", rdata, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    model_rdata = 32'h0;
  endtask

  task automatic test_store_vectors;
    int lat, reqs; logic e; logic [31:0] rd, mwd, ma; logic [3:0] be; logic mwe; bit bok;
    run_txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
    tests_run++;
    if (lat !== 2 || e !== 1'b0) begin
      tests_failed++; $display("FAIL sw_done: got lat=%0d err=%b expected lat=2 err=0", lat, e);
    end
    tests_run++;
    if (ma !== 32'h100 || be !== 4'hF || mwe !== 1'b1 || mwd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL sw_bus: got addr=%h be=%b we=%b wd=%h expected 100 1111 1 deadbeef", ma, be, mwe, mwd);
    end
    run_txn(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 0, 32'h0, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
    tests_run++;
    if (be !== 4'b1000 || mwd !== 32'hA5A5A5A5 || ma !== 32'h100 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_bus: got be=%b wd=%h addr=%h err=%b expected 1000 a5a5a5a5 100 0", be, mwd, ma, e);
    end
  endtask

  task automatic test_load_vectors;
    int lat, reqs; logic e; logic [31:0] rd, mwd, ma; logic [3:0] be; logic mwe; bit bok;
    run_txn(1'b0, 3'd0, 32'h202, 32'h0, 3, 32'h0080FF00, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
    tests_run++;
    if (rd !== 32'hFFFFFF80 || e !== 1'b0 || lat !== 5 || be !== 4'h0 || mwe !== 1'b0) begin
      tests_failed++;
      $display("FAIL lb: got rdata=%h err=%b lat=%0d be=%b we=%b expected ffffff80 0 5 0000 0", rd, e, lat, be, mwe);
    end
    run_txn(1'b0, 3'd4, 32'h202, 32'h0, 3, 32'h0080FF00, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
    tests_run++;
    if (rd !== 32'h00000080 || e !== 1'b0) begin
      tests_failed++; $display("FAIL lbu: got rdata=%h err=%b expected 00000080 0", rd, e);
    end
    model_rdata = 32'h00000080;
  endtask

  task automatic test_timeout;
    int lat, reqs; logic e; logic [31:0] rd, mwd, ma; logic [3:0] be; logic mwe; bit bok;
    run_txn(1'b0, 3'd2, 32'h3C0, 32'h0, -1, 32'h0, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
    tests_run++;
    if (reqs !== TB_TIMEOUT || lat !== TB_TIMEOUT + 1 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout: got reqs=%0d lat=%0d err=%b expected %0d %0d 1", reqs, lat, e, TB_TIMEOUT, TB_TIMEOUT + 1);
    end
    tests_run++;
    if (rd !== model_rdata) begin
      tests_failed++; $display("FAIL timeout_rdata: got %h expected %h", rd, model_rdata);
    end
  endtask

  task automatic test_illegal;
    int lat, reqs; logic e; logic [31:0] rd, mwd, ma; logic [3:0] be; logic mwe; bit bok;
    run_txn(1'b0, 3'd3, 32'h10, 32'h0, 0, 32'h1234, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
    tests_run++;
    if (reqs !== 0 || lat !== 1 || e !== 1'b1 || rd !== model_rdata) begin
      tests_failed++;
      $display("FAIL illegal_load: got reqs=%0d lat=%0d err=%b rdata=%h expected 0 1 1 %h", reqs, lat, e, rd, model_rdata);
    end
    run_txn(1'b1, 3'd4, 32'h10, 32'h55, 0, 32'h0, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
    tests_run++;
    if (reqs !== 0 || lat !== 1 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_store: got reqs=%0d lat=%0d err=%b expected 0 1 1", reqs, lat, e);
    end
  endtask

  task automatic test_misalign;
    int lat, reqs; logic e; logic [31:0] rd, mwd, ma; logic [3:0] be; logic mwe; bit bok;
    run_txn(1'b0, 3'd1, 32'h001, 32'h0, 0, 32'hA1B2C3D4, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
`ifdef MISALIGN_TRAP_EN
    tests_run++;
    if (reqs !== 0 || lat !== 1 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL lh_misalign_trap: got reqs=%0d lat=%0d err=%b expected 0 1 1", reqs, lat, e);
    end
`else
    tests_run++;
    if (reqs !== 1 || be !== 4'h0 || e !== 1'b0 || rd !== 32'hFFFFC3D4) begin
      tests_failed++;
      $display("FAIL lh_misalign_pass: got reqs=%0d be=%b err=%b rdata=%h expected 1 0000 0 ffffc3d4", reqs, be, e, rd);
    end
    model_rdata = 32'hFFFFC3D4;
`endif
  endtask

  task automatic test_random;
    int lat, reqs, xlat, xreqs, d; logic e, xe; logic [31:0] rd, mwd, ma, a, wd, word;
    logic [3:0] be; logic mwe; bit bok, st; logic [2:0] f;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = $urandom; wd = $urandom; word = $urandom;
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      m_expect(st, f, a, d, xlat, xreqs, xe);
      run_txn(st, f, a, wd, d, word, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
      if (xreqs > 0 && !xe && !st) model_rdata = m_load(f, a, word);
      tests_run++;
      if (lat !== xlat || reqs !== xreqs || e !== xe || rd !== model_rdata || !bok) begin
        tests_failed++;
        $display("FAIL rand_ctrl[%0d]: got lat=%0d reqs=%0d err=%b rdata=%h busy_ok=%b expected %0d %0d %b %h 1",
                 i, lat, reqs, e, rd, bok, xlat, xreqs, xe, model_rdata);
      end
      if (xreqs > 0) begin
        tests_run++;
        if (be !== m_be(st, f, a) || ma !== (a & 32'hFFFF_FFFC) || mwe !== st ||
            (st && mwd !== m_wd(f, wd))) begin
          tests_failed++;
          $display("FAIL rand_bus[%0d]: got be=%b addr=%h we=%b wd=%h expected %b %h %b %h",
                   i, be, ma, mwe, mwd, m_be(st, f, a), a & 32'hFFFF_FFFC, st, m_wd(f, wd));
        end
      end
    end
  endtask

  task automatic test_busy_ignore;
    int extra;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h400; mem_ready = 1'b0;
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'd0; addr = 32'h800;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_ignore_bus: got req=%b addr=%h we=%b expected 1 400 0", mem_req, mem_addr, mem_we);
    end
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ready = 1'b0;
    tests_run++;
    if (done !== 1'b1 || rdata !== 32'h12345678 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_ignore_done: got done=%b rdata=%h err=%b expected 1 12345678 0", done, rdata, err);
    end
    model_rdata = 32'h12345678;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || mem_req) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++; $display("FAIL busy_ignore_queue: got %0d extra cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_access;
    int lat, reqs, seen; logic e; logic [31:0] rd, mwd, ma, word; logic [3:0] be; logic mwe; bit bok;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL reset_async_req: got %b expected 0", mem_req);
    end
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen++;
    end
    reset = 1'b0;
    model_rdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      if (done || mem_req) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++; $display("FAIL reset_no_done: got %0d done/req cycles expected 0", seen);
    end
    word = $urandom;
    run_txn(1'b0, 3'd2, 32'h44, 32'h0, 1, word, lat, reqs, e, rd, be, mwd, ma, mwe, bok);
    tests_run++;
    if (lat !== 3 || e !== 1'b0 || rd !== word || ma !== 32'h44) begin
      tests_failed++;
      $display("FAIL reset_restart: got lat=%0d err=%b rdata=%h addr=%h expected 3 0 %h 44", lat, e, rd, ma, word);
    end
    model_rdata = word;
  endtask

  initial begin
    test_reset();
    test_store_vectors();
    test_load_vectors();
    test_timeout();
    test_illegal();
    test_misalign();
    test_busy_ignore();
    test_random();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of cycles mem_req waits for mem_ready before aborting (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse from the decoder requesting a load or store.
REQ-005 is_store  input  1  1 selects store (SB/SH/SW), 0 selects load (LB/LH/LW/LBU/LHU); sampled with start.
REQ-006 funct3  input  3  RV32I load/store width code; sampled with start.
REQ-007 addr  input  32  byte address from the ALU; sampled with start.
REQ-008 wdata  input  32  store data (rs2); sampled with start.
REQ-009 busy  output  1  high from the cycle after start until done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  extended load result; valid while done=1, held until next done.
REQ-012 err  output  1  valid with done; 1 means illegal funct3, misaligned access (when trapped) or timeout.
REQ-013 mem_req  output  1  data-memory request; held high until mem_ready.
REQ-014 mem_we  output  1  write strobe; valid with mem_req.
REQ-015 mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-016 mem_be  output  4  byte enables.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_ready  input  1  memory accepts the write or returns mem_rdata in this cycle.
REQ-019 mem_rdata  input  32  read word; sampled when mem_req and mem_ready are both 1.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE. Transitions: IDLE->ACCESS on a legal start; IDLE->DONE on an illegal or trapped start; ACCESS->DONE on mem_ready or timeout; DONE->IDLE unconditionally.
REQ-021 mem_req = (state==ACCESS); first assertion is the cycle after start; with mem_ready=1 in that cycle, done is asserted 2 cycles after start.
REQ-022 A start while busy is ignored; no queuing.
REQ-023 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; mem_be=0 for loads.
REQ-024 Store data: SB replicates the byte ×4; SH replicates the halfword ×2; SW passes the word through.
REQ-025 Load extract: LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-026 Illegal funct3 (load 011/110/111, store ≥011) -> no mem_req, done with err=1 the next cycle, rdata unchanged.
REQ-027 A timeout counter counts ACCESS cycles; if mem_ready is still low after TIMEOUT cycles, mem_req drops, done fires with err=1, and rdata is unchanged.
REQ-028 err=0 whenever done=1 and none of REQ-026/027/031 applies.

Reset
REQ-029 On reset: state=IDLE; busy, done, err, mem_req, mem_we = 0; mem_be = 0; rdata, mem_addr, mem_wdata = 0; timeout counter = 0.
REQ-030 Reset mid-ACCESS drops mem_req immediately (asynchronously) and produces no done pulse.

Configuration
REQ-031 With MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issue no mem_req and complete via DONE with err=1.
REQ-032 Without MISALIGN_TRAP_EN: the low address bits below the access width are ignored and the access proceeds aligned down; err is never set for misalignment.

Structure
REQ-033 The shared package holds the funct3 load/store encodings, the FSM state enum and the default TIMEOUT constant.
REQ-034 Sub-module load_extend (combinational: funct3, addr[1:0], word -> 32-bit result) implements REQ-025.

Verification
REQ-035 SW addr=0x100, wdata=0xDEADBEEF, mem_ready=1 immediately -> mem_addr=0x100, mem_be=1111, mem_we=1, done 2 cycles after start, err=0.
REQ-036 SB addr=0x103, wdata=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5.
REQ-037 LB addr=0x202, mem_rdata=0x0080FF00, mem_ready after 3 cycles -> rdata=0xFFFFFF80; LBU at the same address -> rdata=0x00000080.
REQ-038 LW with mem_ready held 0, TIMEOUT=16 -> mem_req high 16 cycles, then done with err=1.
REQ-039 LH addr=0x001: with MISALIGN_TRAP_EN -> no mem_req, done with err=1; without it -> mem_be=0, access completes, err=0.
REQ-040 Reset asserted in ACCESS -> mem_req=0 at once, no done pulse; a subsequent start is accepted normally.
